key_debounce: RTL and testbench



---
 rtl/key_debounce.sv | 153 +++++++++++++++
 tb/tb_key_debounce.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// key_debounce: conditions NUM_KEYS raw push-button inputs into a clean
// debounced level plus single-cycle press, release and long-press pulses.
// Each key is an independent lane: 2-flop synchroniser, one shared
// debounce/hold counter and a four-state filter FSM with registered outputs.

module key_debounce_lane #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel_pulse,
    output logic long_pulse
);
    // One counter times both the debounce window and the hold; it never wraps.
    localparam int   CW       = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic ACT_LOW  = logic'(KEY_ACTIVE_LOW != 0);
    localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {S_UP, S_DN_FILT, S_DOWN, S_UP_FILT} state_t;

    logic          sync1, sync2, act;
    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          long_done, long_done_nx;
    logic          level_nx, press_nx, rel_nx, long_nx;

    // Two-flop synchroniser; reset parks it at the released pin level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= ACT_LOW;
            sync2 <= ACT_LOW;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign act = sync2 ^ ACT_LOW;

    // State, timer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_UP;
            cnt        <= '0;
            long_done  <= 1'b0;
            level      <= 1'b0;
            press      <= 1'b0;
            rel_pulse  <= 1'b0;
            long_pulse <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            long_done  <= long_done_nx;
            level      <= level_nx;
            press      <= press_nx;
            rel_pulse  <= rel_nx;
            long_pulse <= long_nx;
        end
    end

    // Filter transitions and timer updates.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        long_done_nx = long_done;
        unique case (state)
            S_UP: begin
                if (act) begin
                    state_nx = S_DN_FILT;
                    cnt_nx   = '0;
                end
            end
            S_DN_FILT: begin
                if (!act) begin
                    state_nx = S_UP;
                end else if (cnt == DEB_MAX) begin
                    state_nx = S_DOWN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            S_DOWN: begin
                if (!act) begin
                    state_nx = S_UP_FILT;
                    cnt_nx   = '0;
                end else if (!long_done && cnt == HOLD_MAX) begin
                    long_done_nx = 1'b1;
                end else if (cnt < HOLD_MAX) begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            S_UP_FILT: begin
                // A glitch back to pressed keeps long_done so the hold cannot re-fire.
                if (act) begin
                    state_nx = S_DOWN;
                    cnt_nx   = '0;
                end else if (cnt == DEB_MAX) begin
                    state_nx     = S_UP;
                    long_done_nx = 1'b0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: state_nx = S_UP;
        endcase
    end

    // Output decode from the transition about to be taken.
    always_comb begin
        level_nx = (state_nx == S_DOWN) || (state_nx == S_UP_FILT);
        press_nx = (state == S_DN_FILT) && (state_nx == S_DOWN);
        rel_nx   = (state == S_UP_FILT) && (state_nx == S_UP);
        long_nx  = !long_done && long_done_nx;
    end
endmodule

module key_debounce #(
    parameter int NUM_KEYS        = 8,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
        key_debounce_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .raw        (key_raw[i]),
            .level      (key_level[i]),
            .press      (key_press[i]),
            .rel_pulse  (key_release[i]),
            .long_pulse (key_long[i])
        );
    end
endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: run-length reference model checked every cycle,
// plus directed scenarios with hand-computed cycle offsets.

module tb_key_debounce;
    localparam int N = 8;
    localparam int D = 4;
    localparam int H = 16;
    localparam bit ACT_LOW = 1'b1;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] key_raw;
    logic [N-1:0] key_level, key_press, key_release, key_long;

    key_debounce #(
        .NUM_KEYS(N), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .KEY_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .key_raw(key_raw),
        .key_level(key_level), .key_press(key_press),
        .key_release(key_release), .key_long(key_long)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a key's accepted level flips once the synchronised
    // pressed/released value has disagreed with it on D+1 consecutive edges.
    // The hold timer counts agreeing edges since the press (or since the
    // edge a release glitch ended); long fires once per press at H.
    bit           ms1[N], ms2[N], mlvl[N], mdone[N];
    int           mis[N], hold_t[N];
    logic [N-1:0] m_level, m_press, m_rel, m_long;

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            ms1[k] = ACT_LOW; ms2[k] = ACT_LOW;
            mlvl[k] = 0; mdone[k] = 0; mis[k] = 0; hold_t[k] = 0;
        end
        m_level = '0; m_press = '0; m_rel = '0; m_long = '0;
    endtask

    task automatic model_step();
        bit a;
        for (int k = 0; k < N; k++) begin
            a = ms2[k] ^ ACT_LOW;
            ms2[k] = ms1[k];
            ms1[k] = key_raw[k];
            m_press[k] = 0; m_rel[k] = 0; m_long[k] = 0;
            if (a != mlvl[k]) begin
                mis[k]++;
                if (mis[k] == D + 1) begin
                    mis[k] = 0;
                    mlvl[k] = a;
                    if (a) begin m_press[k] = 1; hold_t[k] = 0; end
                    else begin m_rel[k] = 1; mdone[k] = 0; end
                end
            end else begin
                if (mlvl[k]) begin
                    if (mis[k] > 0) hold_t[k] = 0;
                    else if (hold_t[k] < H) hold_t[k]++;
                    if (!mdone[k] && hold_t[k] == H) begin
                        m_long[k] = 1; mdone[k] = 1;
                    end
                end
                mis[k] = 0;
            end
            m_level[k] = mlvl[k];
        end
    endtask

    task automatic cmp_vec(input string nm, input logic [N-1:0] d, input logic [N-1:0] e);
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL %s at %0t: dut=%h model=%h", nm, $time, d, e);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Per-scenario recorder: pulse counts and first cycle seen, counted in
    // negedges after the scenario started (cycle 1 follows the first edge).
    int           rc, fpc;
    logic [N-1:0] fpv, lvl_seen;
    int           pcnt[N], rcnt[N], lcnt[N], pfirst[N], rfirst[N], lfirst[N];

    task automatic clr();
        rc = 0; fpc = -1; fpv = '0; lvl_seen = '0;
        for (int k = 0; k < N; k++) begin
            pcnt[k] = 0; rcnt[k] = 0; lcnt[k] = 0;
            pfirst[k] = -1; rfirst[k] = -1; lfirst[k] = -1;
        end
    endtask

    task automatic run_rec(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rc++;
            lvl_seen |= key_level;
            if (key_press != '0 && fpc < 0) begin fpc = rc; fpv = key_press; end
            for (int k = 0; k < N; k++) begin
                if (key_press[k])   begin pcnt[k]++; if (pfirst[k] < 0) pfirst[k] = rc; end
                if (key_release[k]) begin rcnt[k]++; if (rfirst[k] < 0) rfirst[k] = rc; end
                if (key_long[k])    begin lcnt[k]++; if (lfirst[k] < 0) lfirst[k] = rc; end
            end
        end
    endtask

    initial begin
        int thr, tot;
        rst = 1'b1;
        key_raw = '1;
        model_reset();
        fork
            forever begin
                @(posedge clk or posedge rst);
                if (rst) model_reset();
                else begin #1; model_step(); end
            end
            forever begin
                @(negedge clk);
                cmp_vec("level",   key_level,   m_level);
                cmp_vec("press",   key_press,   m_press);
                cmp_vec("release", key_release, m_rel);
                cmp_vec("long",    key_long,    m_long);
            end
        join_none

        clr();
        run_rec(3);
        rst = 1'b0;
        run_rec(10);

        // 1. reset mid-run with all keys held, then release with key 0 held
        key_raw = 8'h00;
        run_rec(10);
        chk("all_pressed_level", key_level, 8'hFF);
        #2 rst = 1'b1;
        #1;
        chk("rst_level",   key_level,   0);
        chk("rst_press",   key_press,   0);
        chk("rst_release", key_release, 0);
        chk("rst_long",    key_long,    0);
        @(negedge clk);
        key_raw = 8'hFE;
        rst = 1'b0;
        clr();
        run_rec(12);
        chk("t1_press0_cycle", pfirst[0], D + 3);
        chk("t1_press0_count", pcnt[0], 1);
        tot = 0;
        for (int k = 1; k < N; k++) tot += pcnt[k];
        chk("t1_other_presses", tot, 0);
        chk("t1_level", key_level, 8'h01);
        key_raw = 8'hFF;
        run_rec(15);

        // 2. clean press/hold/release on key 3
        clr();
        key_raw[3] = 1'b0;
        run_rec(30);
        chk("t2_level_held", key_level[3], 1);
        key_raw[3] = 1'b1;
        chk("t2_press_cycle", pfirst[3], 7);
        chk("t2_long_cycle",  lfirst[3], 7 + 16);
        chk("t2_long_count",  lcnt[3], 1);
        clr();
        run_rec(20);
        chk("t2_release_cycle", rfirst[3], 7);
        chk("t2_release_count", rcnt[3], 1);
        chk("t2_level_after",   key_level[3], 0);

        // 3. bounce shorter than the debounce window on key 5
        clr();
        key_raw[5] = 1'b0; run_rec(3);
        key_raw[5] = 1'b1; run_rec(2);
        key_raw[5] = 1'b0; run_rec(3);
        key_raw[5] = 1'b1; run_rec(20);
        chk("t3_press_count",   pcnt[5], 0);
        chk("t3_release_count", rcnt[5], 0);
        chk("t3_level_seen",    lvl_seen[5], 0);

        // 4. release glitch on key 1 after its long press
        clr();
        key_raw[1] = 1'b0; run_rec(26);
        chk("t4_long_cycle", lfirst[1], 23);
        key_raw[1] = 1'b1; run_rec(2);
        key_raw[1] = 1'b0; run_rec(30);
        chk("t4_long_count",    lcnt[1], 1);
        chk("t4_no_release",    rcnt[1], 0);
        chk("t4_level_kept",    key_level[1], 1);
        key_raw[1] = 1'b1; run_rec(12);
        chk("t4_release_cycle", rfirst[1], 58 + 7);

        // 5. simultaneous presses
        clr();
        key_raw = 8'h5A;
        run_rec(10);
        chk("t5_press_cycle", fpc, 7);
        chk("t5_press_vec",   fpv, 8'hA5);
        chk("t5_level",       key_level, 8'hA5);
        key_raw = 8'hFF;
        run_rec(12);
        chk("t5_level_after", key_level, 0);

        // 6. reset ten cycles into key 7's hold
        clr();
        key_raw[7] = 1'b0;
        run_rec(17);
        chk("t6_press_before", pfirst[7], 7);
        chk("t6_no_long_before", lcnt[7], 0);
        #2 rst = 1'b1;
        #1 chk("t6_rst_level", key_level, 0);
        @(negedge clk);
        rst = 1'b0;
        clr();
        run_rec(20);
        chk("t6_fresh_press", pfirst[7], 7);
        chk("t6_no_long", lcnt[7], 0);
        key_raw = 8'hFF;
        run_rec(12);

        // Randomised traffic with occasional resets, checked by the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 699) == 0) begin
                #2 rst = 1'b1;
            end
            thr = ((c / 500) % 2 != 0) ? 40 : 8;
            for (int k = 0; k < N; k++)
                if ($urandom_range(0, thr - 1) == 0) key_raw[k] = ~key_raw[k];
        end
        @(negedge clk);
        rst = 1'b0;
        key_raw = 8'hFF;
        clr();
        run_rec(30);
        chk("rand_all_released", key_level, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
